// File: rtl/pixel_fetch.sv
// pixel_fetch: video-domain reader of the dual-clock pixel FIFO.
// A 2-entry prefetch buffer is kept topped up from the FIFO. A frame-alignment
// FSM (SYNC/ARMED/RUN) pops one pixel per pixel_en request and uses the FIFO
// position code to lock the pixel stream to the display frame. Blank pixels
// are substituted on underrun or misalignment.
module pixel_fetch #(
    parameter logic [2:0] POS_FRAME_START = 3'd1,
    parameter logic [7:0] BLANK_Y         = 8'd16,
    parameter logic [7:0] BLANK_C         = 8'd128
) (
    input  logic       clk,
    input  logic       clk_en,
    input  logic       rst,
    input  logic [7:0] y_in,
    input  logic [7:0] u_in,
    input  logic [7:0] v_in,
    input  logic [7:0] osd_in,
    input  logic [2:0] position_in,
    input  logic       pixel_rd_empty,
    input  logic       pixel_rd_valid,
    output logic       pixel_rd_en,
    input  logic       frame_start,
    input  logic       pixel_en,
    output logic [7:0] y_out,
    output logic [7:0] u_out,
    output logic [7:0] v_out,
    output logic [7:0] osd_out,
    output logic       pixel_out_valid,
    output logic       underrun,
    output logic       misalign
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    // One buffered FIFO word together with its frame position code.
    typedef struct packed {
        logic [2:0] pos;
        logic [7:0] y;
        logic [7:0] u;
        logic [7:0] v;
        logic [7:0] osd;
    } pix_t;

    state_t     state_q, state_d;
    logic [1:0] count_q, count_d;
    logic       inflight_q, inflight_d;
    logic       first_q, first_d;
    pix_t       buf0_q, buf0_d;
    pix_t       buf1_q, buf1_d;

    logic [7:0] y_q, y_d;
    logic [7:0] u_q, u_d;
    logic [7:0] v_q, v_d;
    logic [7:0] osd_q, osd_d;
    logic       valid_q, valid_d;
    logic       underrun_q, underrun_d;
    logic       misalign_q, misalign_d;

    pix_t       in_word;
    logic       push;
    logic       pop;
    logic       head_valid;
    logic       head_is_start;
    logic       show_head;
    logic       show_blank;

    assign in_word       = '{pos: position_in, y: y_in, u: u_in, v: v_in, osd: osd_in};
    // Only a word we actually asked for is accepted; this also drops a stale
    // response to a read that was issued before a reset.
    assign push          = pixel_rd_valid && inflight_q;
    assign head_valid    = (count_q != 2'd0);
    assign head_is_start = (buf0_q.pos == POS_FRAME_START);

    // Read request: keep buffered plus in-flight words at most 2 so the
    // buffer can never overflow.
    assign pixel_rd_en = clk_en && !rst && !pixel_rd_empty &&
                         ((count_q + {1'b0, inflight_q}) < 2'd2);
    assign inflight_d  = pixel_rd_en;

    // Frame-alignment FSM: decides pops, state moves and what to emit.
    always_comb begin
        state_d    = state_q;
        first_d    = first_q;
        pop        = 1'b0;
        show_head  = 1'b0;
        show_blank = 1'b0;
        underrun_d = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            SYNC: begin
                // Discard words until the head is the first pixel of a frame.
                if (head_valid) begin
                    if (head_is_start) begin
                        state_d = ARMED;
                    end else begin
                        pop = 1'b1;
                    end
                end
                show_blank = pixel_en;
            end
            ARMED: begin
                // Frame start takes effect next cycle; a coincident request is blanked.
                if (frame_start) begin
                    state_d = RUN;
                    first_d = 1'b1;
                end
                show_blank = pixel_en;
            end
            RUN: begin
                if (pixel_en) begin
                    if (!head_valid) begin
                        show_blank = 1'b1;
                        underrun_d = 1'b1;
                        state_d    = SYNC;
                    end else if (!head_is_start || first_q) begin
                        pop       = 1'b1;
                        show_head = 1'b1;
                        first_d   = 1'b0;
                    end else begin
                        // A new frame arrived before the display expected it.
                        show_blank = 1'b1;
                        misalign_d = 1'b1;
                        state_d    = ARMED;
                    end
                end
            end
            default: state_d = SYNC;
        endcase
    end

    // Output pixel selection: head word, blank, or hold.
    always_comb begin
        y_d     = y_q;
        u_d     = u_q;
        v_d     = v_q;
        osd_d   = osd_q;
        valid_d = valid_q;
        if (show_head) begin
            y_d     = buf0_q.y;
            u_d     = buf0_q.u;
            v_d     = buf0_q.v;
            osd_d   = buf0_q.osd;
            valid_d = 1'b1;
        end else if (show_blank) begin
            y_d     = BLANK_Y;
            u_d     = BLANK_C;
            v_d     = BLANK_C;
            osd_d   = 8'd0;
            valid_d = 1'b0;
        end
    end

    // Prefetch buffer update: pop shifts the tail forward, push fills the tail.
    always_comb begin
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        count_d = count_q;
        case ({push, pop})
            2'b01: begin
                buf0_d  = buf1_q;
                count_d = count_q - 2'd1;
            end
            2'b10: begin
                if (count_q == 2'd0) begin
                    buf0_d = in_word;
                end else begin
                    buf1_d = in_word;
                end
                count_d = count_q + 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    buf0_d = in_word;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = in_word;
                end
            end
            default: ;
        endcase
    end

    // Control and output registers; reset flushes the buffer and blanks outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SYNC;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            first_q    <= 1'b0;
            y_q        <= BLANK_Y;
            u_q        <= BLANK_C;
            v_q        <= BLANK_C;
            osd_q      <= 8'd0;
            valid_q    <= 1'b0;
            underrun_q <= 1'b0;
            misalign_q <= 1'b0;
        end else if (clk_en) begin
            state_q    <= state_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            first_q    <= first_d;
            y_q        <= y_d;
            u_q        <= u_d;
            v_q        <= v_d;
            osd_q      <= osd_d;
            valid_q    <= valid_d;
            underrun_q <= underrun_d;
            misalign_q <= misalign_d;
        end
    end

    // Buffer storage; occupancy is tracked by count_q so contents need no reset.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            buf0_q <= buf0_d;
            buf1_q <= buf1_d;
        end
    end

    assign y_out           = y_q;
    assign u_out           = u_q;
    assign v_out           = v_q;
    assign osd_out         = osd_q;
    assign pixel_out_valid = valid_q;
    assign underrun        = underrun_q;
    assign misalign        = misalign_q;

endmodule
